// File: rtl/frame_plot_ctrl.sv
// Sole framebuffer writer: muxes the background-clear sweep and single draw pixels
// onto one registered (x, y, colour, plot) port, re-aligning clear coordinates to RAM colour.
module frame_plot_ctrl #(
    parameter int unsigned XW      = 8,
    parameter int unsigned YW      = 8,
    parameter int unsigned COLW    = 12,
    parameter int unsigned XMAX    = 159,
    parameter int unsigned YMAX    = 119,
    parameter int unsigned CLR_LAT = 1
) (
    input  logic            clk,
    input  logic            reset,

    input  logic            clear_req,
    output logic            clear_busy,
    output logic            frame_done,

    output logic            ClearLock,
    input  logic [XW-1:0]   ClearX,
    input  logic [YW-1:0]   ClearY,
    input  logic [COLW-1:0] ClearColor,

    input  logic            draw_valid,
    output logic            draw_ready,
    input  logic [XW-1:0]   draw_x,
    input  logic [YW-1:0]   draw_y,
    input  logic [COLW-1:0] draw_color,

    output logic [XW-1:0]   x,
    output logic [YW-1:0]   y,
    output logic [COLW-1:0] colour,
    output logic            plot,
    output logic            oob_err
);

    localparam int unsigned   NPix      = (XMAX + 1) * (YMAX + 1);
    localparam int unsigned   CW        = $clog2(NPix);
    localparam logic [CW-1:0] PixLast   = CW'(NPix - 1);
    localparam int unsigned   FW        = (CLR_LAT > 1) ? $clog2(CLR_LAT) : 1;
    localparam logic [FW-1:0] FlushLast = FW'(CLR_LAT - 1);
    localparam logic [XW-1:0] XLim      = XW'(XMAX);
    localparam logic [YW-1:0] YLim      = YW'(YMAX);

    typedef enum logic [1:0] {StIdle, StClear, StFlush} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] pix_cnt_q, pix_cnt_d;
    logic [FW-1:0] flush_cnt_q, flush_cnt_d;
    logic          done_d;

    // Coordinate delay line; entry CLR_LAT-1 lines up with ClearColor.
    logic [XW-1:0] dl_x [CLR_LAT];
    logic [YW-1:0] dl_y [CLR_LAT];
    logic          dl_v [CLR_LAT];

    logic accept;
    logic in_range;

    assign ClearLock  = (state_q == StClear);
    assign clear_busy = (state_q != StIdle);
    assign draw_ready = (state_q == StIdle) && !clear_req;
    assign accept     = draw_valid && draw_ready;
    assign in_range   = (draw_x <= XLim) && (draw_y <= YLim);

    always_comb begin
        state_d     = state_q;
        pix_cnt_d   = pix_cnt_q;
        flush_cnt_d = flush_cnt_q;
        done_d      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (clear_req) begin
                    state_d   = StClear;
                    pix_cnt_d = '0;
                end
            end
            StClear: begin
                pix_cnt_d = pix_cnt_q + CW'(1);
                if (pix_cnt_q == PixLast) begin
                    state_d     = StFlush;
                    pix_cnt_d   = '0;
                    flush_cnt_d = '0;
                end
            end
            StFlush: begin
                if (flush_cnt_q == FlushLast) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end else begin
                    flush_cnt_d = flush_cnt_q + FW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            pix_cnt_q   <= '0;
            flush_cnt_q <= '0;
            frame_done  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pix_cnt_q   <= pix_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            frame_done  <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(CLR_LAT); i++) begin
                dl_x[i] <= '0;
                dl_y[i] <= '0;
                dl_v[i] <= 1'b0;
            end
        end else begin
            dl_x[0] <= ClearX;
            dl_y[0] <= ClearY;
            dl_v[0] <= ClearLock;
            for (int i = 1; i < int'(CLR_LAT); i++) begin
                dl_x[i] <= dl_x[i-1];
                dl_y[i] <= dl_y[i-1];
                dl_v[i] <= dl_v[i-1];
            end
        end
    end

    // Draw pixels are only accepted in idle, when the delay line is already empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            x       <= '0;
            y       <= '0;
            colour  <= '0;
            plot    <= 1'b0;
            oob_err <= 1'b0;
        end else begin
            if (dl_v[CLR_LAT-1]) begin
                x      <= dl_x[CLR_LAT-1];
                y      <= dl_y[CLR_LAT-1];
                colour <= ClearColor;
                plot   <= 1'b1;
            end else if (accept) begin
                x      <= draw_x;
                y      <= draw_y;
                colour <= draw_color;
                plot   <= in_range;
            end else begin
                plot   <= 1'b0;
            end
            if (accept && !in_range) begin
                oob_err <= 1'b1;
            end
        end
    end

endmodule
